// File: rtl/ascon_state_serializer.sv
// Ascon state serializer: captures a 320-bit state snapshot and streams a
// contiguous run of its 64-bit words over a valid/ready interface.
package ascon_pkg;
  typedef logic [63:0]  ascon_word_t;
  typedef logic [319:0] ascon_state_t;
endpackage

module ascon_state_serializer
  import ascon_pkg::*;
#(
  parameter int WORD_WIDTH = 64,
  parameter int NUM_WORDS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [319:0]          s_state,
  input  logic [2:0]            s_first_idx,
  input  logic [2:0]            s_count,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WORD_WIDTH-1:0] m_word,
  output logic [2:0]            m_idx,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic {IDLE, SEND} st_t;

  localparam logic [3:0] NW4      = 4'(NUM_WORDS);
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  st_t          st;
  ascon_state_t snap;
  logic [2:0]   idx;
  logic [2:0]   rem;
  logic [3:0]   sum;
  logic         hs;
  logic         hs_last;
  logic         accept;
  logic         legal;

  function automatic ascon_word_t pick(ascon_state_t s, logic [2:0] i);
    ascon_word_t w;
    w = '0;
    case (i)
      3'd0: w = s[63:0];
      3'd1: w = s[127:64];
      3'd2: w = s[191:128];
      3'd3: w = s[255:192];
      3'd4: w = s[319:256];
      default: w = '0;
    endcase
    return w;
  endfunction

  // 4-bit sum so first+count cannot wrap past the word count
  assign sum     = {1'b0, s_first_idx} + {1'b0, s_count};
  assign legal   = (s_count != 3'd0)
                 & ({1'b0, s_count} <= NW4)
                 & ({1'b0, s_first_idx} <= LAST_IDX)
                 & (sum <= NW4);
  assign hs      = m_valid & m_ready;
  assign hs_last = hs & m_last;
  assign s_ready = (st == IDLE) | hs_last;
  assign accept  = s_valid & s_ready;
  assign m_idx   = idx;
  assign busy    = (st == SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      snap    <= '0;
      idx     <= '0;
      rem     <= '0;
      m_valid <= 1'b0;
      m_word  <= '0;
      m_last  <= 1'b0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept && legal) begin
        st      <= SEND;
        snap    <= s_state;
        idx     <= s_first_idx;
        rem     <= s_count;
        m_valid <= 1'b1;
        m_word  <= pick(s_state, s_first_idx);
        m_last  <= (s_count == 3'd1);
      end else if (accept) begin
        st      <= IDLE;
        err     <= 1'b1;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else if (hs && !m_last) begin
        idx    <= idx + 3'd1;
        rem    <= rem - 3'd1;
        m_word <= pick(snap, idx + 3'd1);
        m_last <= (rem == 3'd2);
      end else if (hs_last) begin
        st      <= IDLE;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_state_serializer.sv
// Scoreboard bench for ascon_state_serializer: a word-list model feeds an
// expectation queue that a free-running monitor drains on each handshake.
module tb_ascon_state_serializer;

  typedef struct {
    logic [63:0] word;
    logic [2:0]  idx;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [319:0] s_state = '0;
  logic [2:0]   s_first_idx = '0;
  logic [2:0]   s_count = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [63:0]  m_word;
  logic [2:0]   m_idx;
  logic         m_last;
  logic         busy;
  logic         err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   exp_err = 0;
  int   seen_err = 0;
  int   rmode = 0;
  logic pat[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int   pp = 0;

  ascon_state_serializer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_state(s_state),
    .s_first_idx(s_first_idx), .s_count(s_count),
    .m_valid(m_valid), .m_ready(m_ready), .m_word(m_word),
    .m_idx(m_idx), .m_last(m_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: begin
        if (pp < 6) begin
          m_ready = pat[pp];
          pp++;
        end else begin
          m_ready = 1'b1;
        end
      end
    endcase
  end

  logic        p_stall = 1'b0;
  logic [63:0] p_word;
  logic [2:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (err) seen_err++;
      if (p_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_word", m_word, p_word);
        chk("stall_idx", 64'(m_idx), 64'(p_idx));
        chk("stall_last", 64'(m_last), 64'(p_last));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(m_idx), 64'hFFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", m_word, e.word);
          chk("idx", 64'(m_idx), 64'(e.idx));
          chk("last", 64'(m_last), 64'(e.last));
        end
      end
      p_stall = m_valid && !m_ready;
      p_word  = m_word;
      p_idx   = m_idx;
      p_last  = m_last;
    end
  end

  // Reference: the request is the list of words S[first..first+count-1].
  task automatic model(logic [319:0] st, int first, int count);
    logic [63:0] w[5];
    for (int i = 0; i < 5; i++) w[i] = st[64*i +: 64];
    if (count >= 1 && count <= 5 && first <= 4 && first + count <= 5) begin
      for (int k = 0; k < count; k++) begin
        exp_t e;
        e.word = w[first + k];
        e.idx  = 3'(first + k);
        e.last = (k == count - 1);
        exp_q.push_back(e);
      end
    end else begin
      exp_err++;
    end
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send_req(logic [319:0] st, int first, int count);
    bit done;
    done = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_state = st;
    s_first_idx = 3'(first);
    s_count = 3'(count);
    for (int n = 0; n < 200 && !done; n++) begin
      if (s_ready) begin
        model(st, first, count);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("accept_timeout", 64'd0, 64'd1);
      s_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  function automatic logic [319:0] rnd_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  initial begin
    logic [319:0] st;
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_word", m_word, 64'd0);
    chk("rst_m_idx", 64'(m_idx), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);

    rmode = 0;
    for (int i = 0; i < 5; i++) st[64*i +: 64] = 64'(i + 1);
    send_req(st, 0, 5);
    chk("full_first_valid", 64'(m_valid), 64'd1);
    chk("full_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_s_ready", 64'(s_ready), 64'(k == 4));
      chk("full_valid", 64'(m_valid), 64'd1);
    end
    @(negedge clk);
    chk("full_idle", 64'(m_valid), 64'd0);
    drain();

    st = rnd_state();
    st[64*3 +: 64] = 64'hDEADBEEF_00000003;
    st[64*4 +: 64] = 64'hCAFEF00D_00000004;
    send_req(st, 3, 2);
    drain();
    chk("tag_idle_busy", 64'(busy), 64'd0);

    pp = 0;
    rmode = 2;
    send_req(rnd_state(), 1, 3);
    s_state = rnd_state();
    drain();
    rmode = 0;

    send_req(rnd_state(), 4, 1);
    send_req(rnd_state(), 0, 2);
    chk("b2b_valid", 64'(m_valid), 64'd1);
    chk("b2b_idx", 64'(m_idx), 64'd0);
    drain();

    send_req(rnd_state(), 4, 2);
    @(negedge clk);
    chk("ill_a_err", 64'(err), 64'd1);
    chk("ill_a_valid", 64'(m_valid), 64'd0);
    chk("ill_a_ready", 64'(s_ready), 64'd1);
    send_req(rnd_state(), 0, 0);
    @(negedge clk);
    chk("ill_b_err", 64'(err), 64'd1);
    chk("ill_b_valid", 64'(m_valid), 64'd0);
    send_req(rnd_state(), 5, 1);
    @(negedge clk);
    chk("ill_c_err", 64'(err), 64'd1);
    chk("ill_c_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("ill_err_pulse", 64'(err), 64'd0);

    send_req(rnd_state(), 0, 5);
    n = 0;
    while (m_idx != 3'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_idx2", 64'(m_idx), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(m_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_last", 64'(m_last), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_req(rnd_state(), 2, 3);
    drain();

    rmode = 1;
    for (int t = 0; t < 40; t++) begin
      send_req(rnd_state(), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 6)));
    end
    drain();
    rmode = 0;
    repeat (3) @(negedge clk);
    chk("err_pulses", 64'(seen_err), 64'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/ascon_state_serializer.md
Name: ascon_state_serializer

Overview:
- Reads a full 320-bit Ascon state, S0..S4, from the permutation datapath.
- Emits a selected contiguous run of 64-bit words over a valid/ready stream, one word per handshake.
- Sits at the output end of the core. It feeds ciphertext, tag and hash words (for example S3,S4 for the tag) to the 64-bit host/bus interface.
- It is the reader counterpart of the word-wise state loader, and uses the package types ascon_state_t and ascon_word_t.

Parameters:
- WORD_WIDTH, 64, bits per output word (fixed by the package; not overridable in practice).
- NUM_WORDS, 5, number of state words S0..S4.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  request valid.
- s_ready  output  1  serializer can accept a request this cycle.
- s_state  input  320  state snapshot (ascon_state_t); word i = s_state[64*i +: 64].
- s_first_idx  input  3  index of the first word to emit (0..4).
- s_count  input  3  number of words to emit (1..5).
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts the word.
- m_word  output  64  current state word.
- m_idx  output  3  index of m_word within the state.
- m_last  output  1  m_word is the final word of the request.
- busy  output  1  request in progress (SEND state).
- err  output  1  one-cycle pulse: illegal request dropped.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- Reset values: FSM=IDLE, m_valid=0, m_word=0, m_idx=0, m_last=0, busy=0, err=0. The captured state register and the remaining-count register clear to 0.
- Reset asserted mid-request aborts immediately. Nothing further is emitted, and the outstanding word is lost.

FSM states:
- IDLE: no request held.
- SEND: a request is being emitted.

Request acceptance:
- s_ready = (state==IDLE) | (m_valid & m_ready & m_last). The second term allows back-to-back requests with zero bubble.
- A request is accepted on s_valid & s_ready.
- A request is legal iff s_count != 0, s_count <= 5, s_first_idx <= 4 and s_first_idx + s_count <= 5. Compute the sum at 4-bit width so it cannot wrap.
- Legal request: capture s_state whole. Load idx=s_first_idx and rem=s_count. Next cycle: SEND, m_valid=1, m_word=word[s_first_idx], m_idx=s_first_idx, m_last=(s_count==1).
- Illegal request: no capture. err=1 for exactly the next cycle. The FSM goes to (or stays in) IDLE, and m_valid deasserts if the last word just completed.

SEND state:
- m_valid=1. m_word, m_idx and m_last are registered outputs and stay stable while m_valid & ~m_ready.
- On m_valid & m_ready with ~m_last: idx+=1, rem-=1. m_word=word[idx+1] next cycle, and m_last=(rem-1==1).
- On m_valid & m_ready with m_last: if a new request is accepted in the same cycle, apply the acceptance rules (legal goes to SEND with the first word; illegal goes to IDLE with err). Otherwise go to IDLE with m_valid=0.
- Latency: the first word is valid 1 cycle after acceptance. Throughput is 1 word/cycle with m_ready held high.
- Input changes on s_state, s_first_idx and s_count while not accepting have no effect. The captured snapshot is immune to upstream state updates.
- busy=1 exactly when in SEND.
- m_valid never drops without a handshake except on reset.
- Words are emitted in ascending index order only. idx never exceeds 4; this is guaranteed by the legality check.

Test Plan:
- Full dump: s_state words S0..S4 = 0x00..01 .. 0x00..05, first=0, count=5, m_ready=1 -> 5 consecutive cycles with m_word 1,2,3,4,5, m_idx 0..4, m_last only on idx 4; first word 1 cycle after accept; s_ready=0 during words 1-4.
- Tag read: first=3, count=2, S3=0xDEADBEEF_00000003, S4=0xCAFEF00D_00000004 -> exactly those two words, m_last on the second, then IDLE.
- Backpressure: count=3, m_ready toggles 0,0,1,0,1,1 -> m_word/m_idx/m_last stable through stalls; exactly 3 handshakes; s_state changed after accept has no effect on the output.
- Back-to-back: request A (first=4, count=1) accepted; request B (first=0, count=2) held valid -> B accepted on A's last handshake; output B0 valid the following cycle with no bubble.
- Illegal requests: (first=4, count=2), (first=0, count=0), (first=5, count=1) -> err pulses one cycle each, m_valid stays 0, s_ready stays 1.
- Async reset mid-request: assert rst between clock edges while in SEND on idx 2 -> m_valid, busy and m_last drop to 0 immediately, with no clock edge needed; the next legal request after rst release behaves normally.
